// File: rtl/i2c_ifm_scheduler.sv
// Walks the kernel window over one ifmap tile and hands each window to img2col; start-to-issue >= 2 cycles, done-to-next-issue >= 2 cycles.
// Holds in ISSUE while img2col is busy or the matrix buffer is full; optional stall_cnt output under `define I2C_SCHED_STALL_CNT_EN.
module i2c_ifm_scheduler #(
    parameter int ADDR_WID = 10,
    parameter int CNT_WID  = 12
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                sched_start,
    input  logic                sched_abort,
    input  logic [2:0]          ksize,
    input  logic [1:0]          stride,
    input  logic [5:0]          tile_length,
    input  logic [5:0]          tile_height,
    input  logic                mat_buf_free,
    input  logic                i2c_ready,
    input  logic                i2c_done,
    output logic                i2c_ifm_start,
    output logic [ADDR_WID-1:0] base_addr,
    output logic                addr_valid,
    output logic [CNT_WID-1:0]  win_cnt,
    output logic                sched_busy,
    output logic                sched_done,
`ifdef I2C_SCHED_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                cfg_err
);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, ADVANCE, DONE} state_t;

    localparam int AREA_LIM = 1 << ADDR_WID;

    state_t      state;
    logic [2:0]  ksize_q;
    logic [1:0]  stride_q;
    logic [5:0]  len_q;
    logic [5:0]  hgt_q;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        abort_seen;

    logic [11:0] area;
    logic [11:0] addr_full;
    logic [7:0]  x_next_end;
    logic [7:0]  y_next_end;
    logic        ksize_ok;
    logic        cfg_bad;
    logic        issue_ok;
    logic        abort_req;

    assign area       = {6'd0, len_q} * {6'd0, hgt_q};
    assign addr_full  = {6'd0, y} * {6'd0, len_q} + {6'd0, x};
    // 8-bit sums so the far edge of the next window never wraps
    assign x_next_end = {2'd0, x} + {6'd0, stride_q} + {5'd0, ksize_q};
    assign y_next_end = {2'd0, y} + {6'd0, stride_q} + {5'd0, ksize_q};
    assign ksize_ok   = (ksize_q == 3'd1) || (ksize_q == 3'd3) || (ksize_q == 3'd5);
    assign cfg_bad    = !ksize_ok || (stride_q == 2'd0)
                      || ({3'd0, ksize_q} > len_q) || ({3'd0, ksize_q} > hgt_q)
                      || (int'({20'd0, area}) > AREA_LIM);
    assign issue_ok   = i2c_ready && mat_buf_free && !i2c_done;
    assign abort_req  = sched_abort || abort_seen;
    assign sched_busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            ksize_q       <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            hgt_q         <= '0;
            x             <= '0;
            y             <= '0;
            abort_seen    <= 1'b0;
            i2c_ifm_start <= 1'b0;
            base_addr     <= '0;
            addr_valid    <= 1'b0;
            win_cnt       <= '0;
            sched_done    <= 1'b0;
            cfg_err       <= 1'b0;
`ifdef I2C_SCHED_STALL_CNT_EN
            stall_cnt     <= '0;
`endif
        end else begin
            i2c_ifm_start <= 1'b0;
            sched_done    <= 1'b0;
            if (state != IDLE && sched_abort)
                abort_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (sched_start) begin
                        ksize_q    <= ksize;
                        stride_q   <= stride;
                        len_q      <= tile_length;
                        hgt_q      <= tile_height;
                        win_cnt    <= '0;
                        cfg_err    <= 1'b0;
                        abort_seen <= 1'b0;
`ifdef I2C_SCHED_STALL_CNT_EN
                        stall_cnt  <= '0;
`endif
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        x     <= '0;
                        y     <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef I2C_SCHED_STALL_CNT_EN
                    if (i2c_ready && !mat_buf_free && stall_cnt != '1)
                        stall_cnt <= stall_cnt + 16'd1;
`endif
                    if (abort_req) begin
                        state <= DONE;
                    end else if (issue_ok) begin
                        base_addr     <= ADDR_WID'(addr_full);
                        i2c_ifm_start <= 1'b1;
                        addr_valid    <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (win_cnt != '1)
                            win_cnt <= win_cnt + 1'b1;
                        addr_valid <= 1'b0;
                        state      <= abort_req ? DONE : ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (x_next_end <= {2'd0, len_q}) begin
                        x     <= x + {4'd0, stride_q};
                        state <= ISSUE;
                    end else if (y_next_end <= {2'd0, hgt_q}) begin
                        x     <= '0;
                        y     <= y + {4'd0, stride_q};
                        state <= ISSUE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    sched_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
